// File: rtl/vigilancia_pkg.sv
// vigilancia_pkg: shared types, sizes and group stepping for the camera-scan monitor
package vigilancia_pkg;
  localparam int NGROUPS = 3;
  localparam int CAMS_PER_GROUP = 3;
  localparam int NCAMS = 9;
  typedef logic [1:0] group_t;
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;
  function automatic group_t next_group(input group_t g);
    return (g == 2'd2) ? 2'd0 : g + 2'd1;
  endfunction
endpackage

// File: rtl/vigilancia_group_decoder.sv
// vigilancia_group_decoder: reduces the camera enables to a live group index and pattern class
module vigilancia_group_decoder
  import vigilancia_pkg::*;
(
  input  logic [NCAMS-1:0] cam,
  output group_t           group,
  output logic             valid,
  output logic             none,
  output logic             multi
);
  logic [NGROUPS-1:0] hit;
  for (genvar k = 0; k < NGROUPS; k++) begin : g_hit
    assign hit[k] = |cam[CAMS_PER_GROUP*k +: CAMS_PER_GROUP];
  end
  always_comb begin
    none  = hit == '0;
    multi = (hit & (hit - 3'd1)) != '0;
    valid = !none && !multi;
    group = hit[2] ? 2'd2 : hit[1] ? 2'd1 : 2'd0;
  end
endmodule

// File: rtl/vigilancia_monitor.sv
// vigilancia_monitor: checks strict 0->1->2 group rotation with bounded dwell,
// counts rotations and latches a sticky alarm with one cause flag per fault.
module vigilancia_monitor
  import vigilancia_pkg::*;
#(
  parameter int MAX_DWELL = 2,
  parameter int NBITS_ROT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCAMS-1:0]     cam,
  input  logic                 clear_alarm,
  output logic [1:0]           active_group,
  output logic                 group_valid,
  output logic [NBITS_ROT-1:0] rotations,
  output logic                 alarm,
  output logic                 seq_err,
  output logic                 stuck_err,
  output logic                 pattern_err
);
  state_t state_q, state_d;
  group_t group_q, group_d, k;
  logic [NBITS_ROT-1:0] rot_q, rot_d;
  logic [3:0] dwell_q, dwell_d;
  logic seq_q, seq_d, stuck_q, stuck_d, pat_q, pat_d;
  logic valid, none, multi;
  vigilancia_group_decoder u_dec (
    .cam   (cam),
    .group (k),
    .valid (valid),
    .none  (none),
    .multi (multi)
  );
  always_comb begin
    state_d = state_q;
    group_d = group_q;
    rot_d   = rot_q;
    dwell_d = dwell_q;
    seq_d   = seq_q;
    stuck_d = stuck_q;
    pat_d   = pat_q;
    case (state_q)
      IDLE: begin
        if (multi) begin
          pat_d   = 1'b1;
          state_d = FAULT;
        end else if (valid) begin
          state_d = TRACK;
          group_d = k;
          dwell_d = 4'd1;
        end
      end
      TRACK: begin
        if (!valid) begin
          pat_d   = 1'b1;
          state_d = FAULT;
        end else if (k == group_q) begin
          if (dwell_q == 4'(MAX_DWELL)) begin
            stuck_d = 1'b1;
            state_d = FAULT;
          end else dwell_d = dwell_q + 4'd1;
        end else if (k == next_group(group_q)) begin
          group_d = k;
          dwell_d = 4'd1;
          rot_d   = (group_q == 2'd2) ? rot_q + 1'b1 : rot_q;
        end else begin
          seq_d   = 1'b1;
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (clear_alarm) begin
          state_d = IDLE;
          seq_d   = 1'b0;
          stuck_d = 1'b0;
          pat_d   = 1'b0;
          dwell_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      group_q <= 2'd0;
      rot_q   <= '0;
      dwell_q <= 4'd0;
      seq_q   <= 1'b0;
      stuck_q <= 1'b0;
      pat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      rot_q   <= rot_d;
      dwell_q <= dwell_d;
      seq_q   <= seq_d;
      stuck_q <= stuck_d;
      pat_q   <= pat_d;
    end
  end
  assign active_group = group_q;
  assign group_valid  = state_q == TRACK;
  assign alarm        = state_q == FAULT;
  assign rotations    = rot_q;
  assign seq_err      = seq_q;
  assign stuck_err    = stuck_q;
  assign pattern_err  = pat_q;
endmodule

// File: tb/tb_vigilancia_monitor.sv
// tb_vigilancia_monitor: table-driven vectors plus rotation-wrap and async-reset sequences
module tb_vigilancia_monitor;
  logic clk = 1'b0;
  logic reset;
  logic [8:0] cam;
  logic clear_alarm;
  logic [1:0] active_group;
  logic group_valid;
  logic [1:0] rotations;
  logic alarm, seq_err, stuck_err, pattern_err;
  logic [8:0] obs;
  int n_run = 0;
  int n_fail = 0;
  localparam logic [8:0] G0 = 9'h004, G1 = 9'h020, G2 = 9'h100, GM = 9'h009;
  typedef struct {
    logic [8:0] cam;
    logic       clr;
    logic [8:0] exp;
  } vec_t;
  vec_t tv[$];
  always #5 clk = ~clk;
  vigilancia_monitor #(.MAX_DWELL(2), .NBITS_ROT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .cam          (cam),
    .clear_alarm  (clear_alarm),
    .active_group (active_group),
    .group_valid  (group_valid),
    .rotations    (rotations),
    .alarm        (alarm),
    .seq_err      (seq_err),
    .stuck_err    (stuck_err),
    .pattern_err  (pattern_err)
  );
  assign obs = {active_group, group_valid, rotations, alarm, seq_err, stuck_err, pattern_err};
  function automatic logic [8:0] mk(input int g, v, r, a, s, t, p);
    return {2'(g), 1'(v), 2'(r), 1'(a), 1'(s), 1'(t), 1'(p)};
  endfunction
  task automatic add(input logic [8:0] c, input logic cl, input logic [8:0] e);
    tv.push_back('{cam: c, clr: cl, exp: e});
  endtask
  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got grp=%0d val=%0b rot=%0d alm=%0b seq=%0b stk=%0b pat=%0b, want grp=%0d val=%0b rot=%0d alm=%0b seq=%0b stk=%0b pat=%0b",
               name, got[8:7], got[6], got[5:4], got[3], got[2], got[1], got[0],
               exp[8:7], exp[6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask
  task automatic step(input logic [8:0] c, input logic cl);
    @(negedge clk);
    cam = c;
    clear_alarm = cl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int exp_rot;
    reset = 1'b0;
    cam = '0;
    clear_alarm = 1'b0;
    for (int i = 0; i < 5; i++) add(9'h000, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    add(G0, 0, mk(0, 1, 0, 0, 0, 0, 0));
    add(G1, 0, mk(1, 1, 0, 0, 0, 0, 0));
    add(G2, 0, mk(2, 1, 0, 0, 0, 0, 0));
    add(G2, 0, mk(2, 1, 0, 0, 0, 0, 0));
    add(G0, 0, mk(0, 1, 1, 0, 0, 0, 0));
    add(G1, 0, mk(1, 1, 1, 0, 0, 0, 0));
    add(G1, 0, mk(1, 1, 1, 0, 0, 0, 0));
    add(G1, 0, mk(1, 0, 1, 1, 0, 1, 0));
    add(9'h000, 0, mk(1, 0, 1, 1, 0, 1, 0));
    add(G1, 1, mk(1, 0, 1, 0, 0, 0, 0));
    add(G0, 0, mk(0, 1, 1, 0, 0, 0, 0));
    add(G2, 0, mk(0, 0, 1, 1, 1, 0, 0));
    add(G1, 1, mk(0, 0, 1, 0, 0, 0, 0));
    add(G0, 0, mk(0, 1, 1, 0, 0, 0, 0));
    add(GM, 0, mk(0, 0, 1, 1, 0, 0, 1));
    add(9'h000, 1, mk(0, 0, 1, 0, 0, 0, 0));
    add(G2, 0, mk(2, 1, 1, 0, 0, 0, 0));
    add(9'h000, 0, mk(2, 0, 1, 1, 0, 0, 1));
    add(9'h000, 1, mk(2, 0, 1, 0, 0, 0, 0));
    add(GM, 0, mk(2, 0, 1, 1, 0, 0, 1));
    add(9'h000, 1, mk(2, 0, 1, 0, 0, 0, 0));
    #12;
    check("reset_state", obs, mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    foreach (tv[i]) begin
      step(tv[i].cam, tv[i].clr);
      check($sformatf("vec%0d", i), obs, tv[i].exp);
    end
    step(G0, 0);
    check("wrap_start", obs, mk(0, 1, 1, 0, 0, 0, 0));
    exp_rot = 1;
    for (int r = 0; r < 5; r++) begin
      step(G1, 0);
      step(G2, 0);
      step(G0, 0);
      exp_rot = (exp_rot + 1) % 4;
      check($sformatf("wrap_rot%0d", r), obs, mk(0, 1, exp_rot, 0, 0, 0, 0));
    end
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", obs, mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    step(G1, 0);
    check("post_reset", obs, mk(1, 1, 0, 0, 0, 0, 0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
